// File: rtl/denorm_shift_48.sv
// rtl/denorm_shift_48.sv - 3-stage denormalizing right shifter with sticky and zero flags
module denorm_shift_48 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_v,
  input  logic [5:0]  in_p,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic        out_sticky,
  output logic        out_zero
);

  logic        s1_valid, s2_valid, s3_valid;
  logic [47:0] s1_data, s2_data, s3_data;
  logic [3:0]  s1_rem;
  logic [1:0]  s2_rem;
  logic        s1_sticky, s2_sticky, s3_sticky;
  logic        s1_zero, s2_zero, s3_zero;

  logic        s1_can, s2_can, s3_can;
  logic [47:0] s1_data_n, s2_data_n, s3_data_n;
  logic        s1_sticky_n, s2_sticky_n, s3_sticky_n;
  logic        s1_zero_n;
  logic [3:0]  s2_amt;
  logic [1:0]  s3_amt;

  // A stage can take new contents when empty or when its current beat moves on.
  assign s3_can   = !s3_valid || out_ready;
  assign s2_can   = !s2_valid || s3_can;
  assign s1_can   = !s1_valid || s2_can;
  assign in_ready = s1_can;

  // Coarse 16-bit steps; a step of 3 (>=48) saturates the mantissa to zero.
  always_comb begin
    s1_data_n   = '0;
    s1_sticky_n = 1'b0;
    s1_zero_n   = 1'b0;
    if (!in_v) begin
      s1_zero_n = 1'b1;
    end else begin
      case (in_p[5:4])
        2'd0: s1_data_n = in_data;
        2'd1: begin
          s1_data_n   = {16'd0, in_data[47:16]};
          s1_sticky_n = |in_data[15:0];
        end
        2'd2: begin
          s1_data_n   = {32'd0, in_data[47:32]};
          s1_sticky_n = |in_data[31:0];
        end
        default: begin
          s1_sticky_n = |in_data;
          s1_zero_n   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    s2_amt      = {s1_rem[3:2], 2'b00};
    s2_data_n   = s1_data >> s2_amt;
    s2_sticky_n = s1_sticky | (|(s1_data & ((48'd1 << s2_amt) - 48'd1)));
  end

  always_comb begin
    s3_amt      = s2_rem;
    s3_data_n   = s2_data >> s3_amt;
    s3_sticky_n = s2_sticky | (|(s2_data & ((48'd1 << s3_amt) - 48'd1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_rem    <= '0;
      s1_sticky <= 1'b0;
      s1_zero   <= 1'b0;
    end else if (s1_can) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data   <= s1_data_n;
        s1_rem    <= in_p[3:0];
        s1_sticky <= s1_sticky_n;
        s1_zero   <= s1_zero_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_rem    <= '0;
      s2_sticky <= 1'b0;
      s2_zero   <= 1'b0;
    end else if (s2_can) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data   <= s2_data_n;
        s2_rem    <= s1_rem[1:0];
        s2_sticky <= s2_sticky_n;
        s2_zero   <= s1_zero;
      end
    end
  end

  // Output register holds its beat while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid  <= 1'b0;
      s3_data   <= '0;
      s3_sticky <= 1'b0;
      s3_zero   <= 1'b0;
    end else if (s3_can) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_data   <= s3_data_n;
        s3_sticky <= s3_sticky_n;
        s3_zero   <= s2_zero;
      end
    end
  end

  assign out_valid  = s3_valid;
  assign out_data   = s3_data;
  assign out_sticky = s3_sticky;
  assign out_zero   = s3_zero;

endmodule

// File: tb/tb_denorm_shift_48.sv
// tb/tb_denorm_shift_48.sv - scoreboard bench for denorm_shift_48
module tb_denorm_shift_48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_v;
  logic [5:0]  in_p;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_sticky;
  logic        out_zero;

  denorm_shift_48 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_v(in_v), .in_p(in_p), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sticky(out_sticky), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  p;
    logic [47:0] d;
  } stim_t;

  typedef struct {
    logic [49:0] exp;
    int          cyc;
  } sb_t;

  stim_t stim[$];
  sb_t   sb[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {data, sticky, zero}
  function automatic logic [49:0] model(input logic v, input logic [5:0] p, input logic [47:0] d);
    logic [63:0] mask;
    if (!v) return {48'd0, 1'b0, 1'b1};
    if (p >= 6'd48) return {48'd0, |d, 1'b1};
    mask = (64'd1 << p) - 64'd1;
    return {d >> p, |({16'd0, d} & mask), 1'b0};
  endfunction

  task automatic push(input logic v, input logic [5:0] p, input logic [47:0] d);
    stim_t s;
    s.v = v; s.p = p; s.d = d;
    stim.push_back(s);
  endtask

  // mode 0: out_ready=1, mode 1: 1-0-0 pattern, mode 2: out_ready=0
  task automatic run(input int mode, input int budget, input bit expect_drain);
    int n = 0;
    sb_t e;
    while ((stim.size() > 0 || sb.size() > 0) && n < budget) begin
      @(negedge clk);
      in_valid = (stim.size() > 0);
      if (stim.size() > 0) begin
        in_v = stim[0].v; in_p = stim[0].p; in_data = stim[0].d;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 3 == 0);
        default: out_ready = 1'b0;
      endcase
      #1;
      check("in_ready", {63'd0, in_ready}, {63'd0, (sb.size() < 3) || out_ready});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", {14'd0, out_data, out_sticky, out_zero}, {14'd0, e.exp});
          if (mode == 0) check("latency", 64'(cyc - e.cyc), 64'd3);
        end
      end
      if (in_valid && in_ready) begin
        e.exp = model(stim[0].v, stim[0].p, stim[0].d);
        e.cyc = cyc;
        sb.push_back(e);
        void'(stim.pop_front());
      end
      cyc++;
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (expect_drain) check("drain_timeout", 64'(stim.size() + sb.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    rst_n = 1'b0; in_valid = 1'b0; in_v = 1'b0; in_p = '0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_bits", {14'd0, out_data, out_sticky, out_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // directed cases
    push(1'b1, 6'd4,  48'h8000_0000_000F);
    push(1'b1, 6'd0,  48'hFFFF_FFFF_FFFF);
    push(1'b1, 6'd47, 48'h8000_0000_0001);
    push(1'b0, 6'd5,  48'hFFFF_FFFF_FFFF);
    push(1'b1, 6'd50, 48'h8000_0000_0000);
    push(1'b1, 6'd48, 48'h8000_0000_0000);
    push(1'b1, 6'd16, 48'h8000_0000_8000);
    push(1'b1, 6'd32, 48'hC000_0001_0000);
    run(0, 200, 1'b1);

    // backpressure with shift amounts 0..9
    for (int i = 0; i < 10; i++) begin
      r = {$urandom, $urandom};
      push(1'b1, 6'(i), {1'b1, r[46:0]});
    end
    run(1, 300, 1'b1);

    // full-rate random stream
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom};
      push(($urandom_range(0, 9) != 0), 6'($urandom_range(0, 63)), {1'b1, r[46:0]});
    end
    run(0, 400, 1'b1);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) push(1'b1, 6'(i + 1), 48'hFFFF_0000_FFFF);
    run(2, 6, 1'b0);
    check("held_beats", 64'(sb.size()), 64'd3);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_bits", {14'd0, out_data, out_sticky, out_zero}, 64'd0);
    sb.delete();
    stim.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("stale_beat", {63'd0, out_valid}, 64'd0);
    end

    // traffic still flows after reset
    push(1'b1, 6'd4, 48'h8000_0000_000F);
    run(0, 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
